// File: rtl/dm_pkg.sv
// dm_pkg: shared types, constants and lane helpers for the sized data memory
package dm_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_t;
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic logic [WORD_BYTES-1:0] lane_mask(size_t sz, logic [1:0] a);
    return sz == SZ_B ? 4'b0001 << a : sz == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) : sz == SZ_W ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] extend(size_t sz, logic uns, logic [31:0] v);
    return sz == SZ_B ? {{24{!uns && v[7]}}, v[7:0]} : sz == SZ_H ? {{16{!uns && v[15]}}, v[15:0]} : v;
  endfunction
endpackage

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt: store lane mask/replication and load extract/extend
module dm_lane_fmt
  import dm_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);
  assign be = lane_mask(size, lane);
  assign wword = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
  assign rdata = extend(size, zero_ext, rword >> {lane, 3'b000});
endmodule

// File: rtl/dm_sized.sv
// dm_sized: word-organised data RAM with sized loads/stores, checks and clear sweep
module dm_sized
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  state_t state, state_nx;
  logic [IW-1:0] clr_idx, idx;
  logic acc, err;
  logic [3:0] be;
  logic [31:0] wword, ldata;
  size_t sz;
  assign sz = size_t'(req_size);
  assign idx = req_addr[IW+1:2];
  assign req_ready = state == RUN && (!rsp_valid || rsp_ready);
  assign acc = req_valid && req_ready && !rst;
  // range compare is one bit wider so a full address space never aliases to zero
  assign err = sz == SZ_RSV || (sz == SZ_H && req_addr[0]) || (sz == SZ_W && req_addr[1:0] != 2'b00) ||
               {1'b0, req_addr} >= (ADDR_W+1)'(WORD_BYTES * DEPTH_WORDS);
  dm_lane_fmt u_fmt (
    .size(sz),
    .lane(req_addr[1:0]),
    .zero_ext(req_unsigned),
    .wdata(req_wdata),
    .rword(mem[idx]),
    .be(be),
    .wword(wword),
    .rdata(ldata)
  );
  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_idx == IW'(DEPTH_WORDS - 1)) state_nx = RUN;
  end
  always_ff @(posedge clk) begin
    state <= rst ? CLEAR : state_nx;
    clr_idx <= rst || state != CLEAR ? '0 : clr_idx + 1'b1;
  end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[clr_idx] <= '0;
    else if (acc && req_we && !err)
      for (int i = 0; i < WORD_BYTES; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_err <= err;
      rsp_rdata <= err || req_we ? '0 : ldata;
    end else if (rsp_ready) rsp_valid <= 1'b0;
endmodule

// File: tb/tb_dm_sized.sv
// tb_dm_sized: randomized and directed checks of dm_sized against a byte-addressed model
module tb_dm_sized;
  localparam int D = 64;
  localparam int AW = 12;
  typedef struct packed {logic [31:0] rd; logic err;} rsp_t;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 0;
  logic [1:0] req_size = 0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0] mb [4*D];
  rsp_t q[$];
  logic [31:0] last_rd;
  logic last_err;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dm_sized #(.DEPTH_WORDS(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic rsp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [AW-1:0] a, input logic [31:0] wd);
    rsp_t r;
    int n, ai;
    ai = int'(a);
    n = 1 << sz;
    r.rd = '0;
    r.err = sz == 2'd3 || ai % n != 0 || ai >= 4 * D;
    if (r.err) return r;
    for (int i = 0; i < n; i++)
      if (we) mb[ai+i] = wd[8*i +: 8];
      else r.rd[8*i +: 8] = mb[ai+i];
    if (!we && !uns && n < 4 && r.rd[8*n-1])
      for (int i = n; i < 4; i++) r.rd[8*i +: 8] = 8'hFF;
    return r;
  endfunction
  task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [AW-1:0] a, input logic [31:0] wd, input logic rr, output logic acc);
    rsp_t r;
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; rsp_ready = rr;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(q.size() == 0 || rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rsp_rdata", rsp_rdata, q[0].rd);
      chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
    end
    acc = v && req_ready;
    if (q.size() != 0 && rr) begin
      r = q.pop_front();
      last_rd = rsp_rdata;
      last_err = rsp_err;
    end
    if (acc) q.push_back(model(we, sz, uns, a, wd));
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [AW-1:0] a, input logic [31:0] wd);
    logic acc;
    int n = 0;
    last_rd = 'x;
    last_err = 'x;
    do begin
      step(1'b1, we, sz, uns, a, wd, 1'b1, acc);
      n++;
    end while (!acc && n < 8);
    chk("accept", 32'(acc), 32'd1);
    step(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1, acc);
  endtask
  task automatic do_reset();
    int cnt = 0;
    rst = 1; req_valid = 0; rsp_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 0;
    while (!req_ready && cnt < D + 8) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("ready_latency", 32'(cnt), 32'(D));
    q.delete();
    foreach (mb[i]) mb[i] = 8'h00;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic acc;
    do_reset();
    op(1'b0, 2'd2, 1'b0, 12'h000, '0);
    chk("ld_w0", last_rd, 32'h0);
    op(1'b1, 2'd2, 1'b0, 12'h010, 32'h8899AABB);
    op(1'b0, 2'd0, 1'b0, 12'h013, '0);
    chk("ld_b13_s", last_rd, 32'hFFFFFF88);
    op(1'b0, 2'd0, 1'b1, 12'h013, '0);
    chk("ld_b13_u", last_rd, 32'h00000088);
    op(1'b1, 2'd0, 1'b0, 12'h011, 32'h0000005A);
    op(1'b0, 2'd2, 1'b0, 12'h010, '0);
    chk("ld_w10", last_rd, 32'h88995ABB);
    op(1'b0, 2'd1, 1'b0, 12'h012, '0);
    chk("ld_h12_s", last_rd, 32'hFFFF8899);
    op(1'b1, 2'd2, 1'b0, 12'h002, 32'h11111111);
    chk("err_w2", 32'(last_err), 32'd1);
    op(1'b1, 2'd1, 1'b0, 12'h005, 32'h22222222);
    chk("err_h5", 32'(last_err), 32'd1);
    op(1'b0, 2'd2, 1'b0, AW'(4 * D), '0);
    chk("err_range", 32'(last_err), 32'd1);
    chk("err_range_rd", last_rd, 32'h0);
    op(1'b1, 2'd2, 1'b0, AW'(4 * D), 32'h33333333);
    op(1'b1, 2'd3, 1'b0, 12'h004, 32'h44444444);
    chk("err_rsv", 32'(last_err), 32'd1);
    op(1'b0, 2'd2, 1'b0, 12'h000, '0);
    chk("unchanged_w0", last_rd, 32'h0);
    op(1'b0, 2'd2, 1'b0, 12'h004, '0);
    chk("unchanged_w4", last_rd, 32'h0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 12'h010, '0, 1'b0, acc);
    chk("bp_accept", 32'(acc), 32'd1);
    repeat (3) step(1'b1, 1'b0, 2'd1, 1'b0, 12'h012, '0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0, 1'b1, AW'(16 + i), '0, 1'b1, acc);
    repeat (2) step(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1, acc);
    for (int k = 0; k < 500; k++) begin
      logic [AW-1:0] a;
      logic [1:0] sz;
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 9) == 0 ? AW'($urandom_range(4 * D - 8, 4 * D + 8)) : AW'($urandom_range(0, 31));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~AW'((1 << sz) - 1);
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
           a, $urandom, $urandom_range(0, 3) != 0, acc);
    end
    repeat (2) step(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1, acc);
    op(1'b1, 2'd2, 1'b0, 12'h020, 32'hDEADBEEF);
    op(1'b0, 2'd2, 1'b0, 12'h020, '0);
    chk("ld_w20", last_rd, 32'hDEADBEEF);
    step(1'b1, 1'b0, 2'd2, 1'b0, 12'h020, '0, 1'b0, acc);
    do_reset();
    op(1'b0, 2'd2, 1'b0, 12'h020, '0);
    chk("ld_w20_clr", last_rd, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_sized.md
# dm_sized

Parametrised successor to the byte-store data memory: a word-organised data RAM serving byte, halfword and word loads and stores. Loads are signed or unsigned; stores use per-lane byte enables. Accesses pass through a valid/ready request port and a registered response port, with misalignment and range checking. After reset the block runs a hardware clear sweep before it accepts requests. It sits between the CPU's MEM stage and the data-memory storage.

## Interface
- DEPTH_WORDS, 1024: storage depth in 32-bit words; power of two, ≥ 4
- ADDR_W, 12: byte-address width; must satisfy 2^ADDR_W ≥ 4·DEPTH_WORDS
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load: zero-extend instead of sign-extend; ignored for stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response held until consumed
- rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected: misaligned, out of range, or reserved size

## Operation
- FSM states: CLEAR, RUN.
- rst → CLEAR with clr_idx = 0.
- CLEAR: writes word clr_idx = 0 each cycle and increments clr_idx. After the write of index DEPTH_WORDS-1 the FSM enters RUN. req_ready = 0 throughout.
- RUN: req_ready = !rsp_valid || rsp_ready (single-entry response register, so full throughput when rsp_ready is held high).
- Error checks on an accepted request, evaluated in this order:
  - req_size == 11 → error.
  - Half access with addr[0] ≠ 0, or word access with addr[1:0] ≠ 0 → error.
  - addr ≥ 4·DEPTH_WORDS → error.
- Any error: no write occurs, rsp_err = 1, rsp_rdata = 0.
- Store:
  - Word index = addr[ADDR_W-1:2].
  - Lane mask: byte → one lane at addr[1:0]; half → lanes {addr[1],0} and {addr[1],1}; word → all four lanes.
  - Data is replicated into the selected lanes; unselected lanes are unchanged.
  - Response: rsp_err = 0, rsp_rdata = 0.
- Load:
  - Read the word, shift the addressed lane(s) down to bit 0.
  - Extend from bit 7 (byte) or bit 15 (half); zero-extend if req_unsigned.
  - Word loads are returned unmodified.
- Lane order is little-endian: byte address 4k+0 maps to word bits [7:0].
- rst in RUN or mid-CLEAR: the FSM restarts CLEAR from index 0, rsp_valid clears, and memory contents become zero after the sweep.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, clr_idx 0, state CLEAR.
- First request can be accepted DEPTH_WORDS cycles after the cycle rst is sampled low.
- Latency: a request accepted at edge N produces rsp_valid = 1 after edge N, so its response is visible during cycle N+1.
- The store write commits at edge N.
- Read-after-write: a load accepted at edge N+1 to the same word sees data stored at edge N.
- Backpressure: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err are stable and req_ready = 0.
- rsp_valid clears on consume unless a new request is accepted at the same edge. In that case the register is reloaded and rsp_valid stays 1.

## Structure
- Package dm_pkg holds:
  - enum size_t {SZ_B, SZ_H, SZ_W, SZ_RSV};
  - lane-mask and extend helper functions;
  - constant WORD_BYTES = 4.
- Sub-module dm_lane_fmt (combinational) computes the store lane mask, the replicated write data and the load extract/extend. It is instantiated once.
- Top level holds the RAM array, the CLEAR/RUN FSM, clr_idx and the response register.

## Test plan
- Reset then idle: req_ready stays 0 for exactly DEPTH_WORDS cycles, then rises. A word load from 0x000 returns 0x00000000.
- Store word 0x8899AABB @0x010, then load byte @0x013 signed → 0xFFFFFF88. The same load with req_unsigned → 0x00000088.
- Store byte 0x5A @0x011 over 0x8899AABB, then load word @0x010 → 0x88995ABB. Load half @0x012 signed → 0xFFFF8899.
- Misaligned and out-of-range requests: word @0x002, half @0x005, and word @ 4·DEPTH_WORDS each → rsp_err = 1, rsp_rdata = 0, and memory unchanged (verified by a following load).
- Backpressure: hold rsp_ready = 0 for 3 cycles with req_valid high → response stable and req_ready = 0. On release, one response is consumed per cycle with no loss.
- rst pulse mid-stream after writing 0xDEADBEEF @0x020 → CLEAR rerun, and a load @0x020 returns 0.
